// File: rtl/sysctrl_gen.sv
`default_nettype none
// ============================================================================
//  Module   : sysctrl_gen
//  Purpose  : MCU system-control endpoint. Decodes framed SPI bytes into
//             status/LED/colour/config/interrupt commands. Define
//             SYSCTRL_GEN_READBACK_EN to enable cmd 7 config readback.
//  Revision : 1.0 - initial release
// ============================================================================
module sysctrl_gen #(
  parameter logic [7:0]         CORE_ID  = 8'h03,
  parameter int                 NVARS    = 26,
  parameter logic [NVARS*8-1:0] CFG_INIT = '0,
  parameter int                 INT_W    = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               data_in_strobe,
  input  logic               data_in_start,
  input  logic [7:0]         data_in,
  output logic [7:0]         data_out,
  output logic               int_out_n,
  input  logic [INT_W-2:0]   int_in,
  input  logic [1:0]         buttons,
  output logic [1:0]         leds,
  output logic [23:0]        color,
  output logic [NVARS*8-1:0] cfg,
  output logic [NVARS-1:0]   cfg_wr
);

  localparam logic [7:0] c_id_base = 8'h41;
  localparam logic [3:0] c_st_max  = 4'd15;

  logic [7:0]       r_cmd;
  logic [3:0]       r_st;
  logic [7:0]       r_id;
  logic [7:0]       r_data_out;
  logic [1:0]       r_leds;
  logic [23:0]      r_color;
  logic [7:0]       r_cfg [NVARS];
  logic [NVARS-1:0] r_cfg_wr;
  logic [INT_W-1:0] r_pending;
  logic [INT_W-1:0] r_mask;
  logic [INT_W-2:0] r_int_prev;

  logic             w_exec;
  logic [7:0]       w_rev;
  logic [NVARS-1:0] w_hit;
  logic [INT_W-1:0] w_set;
  logic [INT_W-1:0] w_ack;

  assign w_exec = data_in_strobe & ~data_in_start & (r_st != 4'd0);
  assign w_set  = {int_in & ~r_int_prev, 1'b0};
  assign w_ack  = (w_exec && r_cmd == 8'd5 && r_st == 4'd1) ? data_in[INT_W-1:0] : '0;

  always_comb begin
    w_rev = '0;
    for (int b = 0; b < 8; b++) begin
      w_rev[b] = data_in[7-b];
    end
  end

  for (genvar k = 0; k < NVARS; k++) begin : g_var
    assign w_hit[k]        = (r_id == c_id_base + 8'(k));
    assign cfg[k*8 +: 8]   = r_cfg[k];
  end

`ifdef SYSCTRL_GEN_READBACK_EN
  logic [7:0] w_rd;

  // Out-of-range ids read back as all ones.
  always_comb begin
    w_rd = 8'hff;
    for (int k = 0; k < NVARS; k++) begin
      if (w_hit[k]) w_rd = r_cfg[k];
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd      <= '0;
      r_st       <= '0;
      r_id       <= '0;
      r_data_out <= '0;
      r_leds     <= '0;
      r_color    <= '0;
      r_cfg_wr   <= '0;
      r_pending  <= {{(INT_W-1){1'b0}}, 1'b1};
      r_mask     <= {{(INT_W-1){1'b0}}, 1'b1};
      r_int_prev <= '0;
      for (int k = 0; k < NVARS; k++) begin
        r_cfg[k] <= CFG_INIT[k*8 +: 8];
      end
    end else begin
      r_cfg_wr   <= '0;
      r_int_prev <= int_in;
      // A new edge on a bit being acked in the same cycle keeps it set.
      r_pending  <= (r_pending & ~w_ack) | w_set;

      if (data_in_strobe && data_in_start) begin
        r_cmd <= data_in;
        r_st  <= 4'd1;
      end else if (w_exec) begin
        if (r_st != c_st_max) r_st <= r_st + 4'd1;
        case (r_cmd)
          8'd0: begin
            case (r_st)
              4'd1:    r_data_out <= 8'h5c;
              4'd2:    r_data_out <= 8'h42;
              4'd3:    r_data_out <= CORE_ID;
              4'd4:    r_data_out <= 8'(NVARS);
              default: ;
            endcase
          end
          8'd1: begin
            if (r_st == 4'd1) r_leds <= data_in[1:0];
          end
          8'd2: begin
            case (r_st)
              4'd1:    r_color[15:8]  <= w_rev;
              4'd2:    r_color[7:0]   <= w_rev;
              4'd3:    r_color[23:16] <= w_rev;
              default: ;
            endcase
          end
          8'd3: begin
            r_data_out <= {6'b0, buttons};
          end
          8'd4: begin
            if (r_st == 4'd1) begin
              r_id <= data_in;
            end else if (r_st == 4'd2) begin
              for (int k = 0; k < NVARS; k++) begin
                if (w_hit[k]) begin
                  r_cfg[k]    <= data_in;
                  r_cfg_wr[k] <= 1'b1;
                end
              end
            end
          end
          8'd5: begin
            r_data_out <= 8'(r_pending);
          end
          8'd6: begin
            if (r_st == 4'd1) r_mask <= data_in[INT_W-1:0] | {{(INT_W-1){1'b0}}, 1'b1};
          end
`ifdef SYSCTRL_GEN_READBACK_EN
          8'd7: begin
            if (r_st == 4'd1) begin
              r_id <= data_in;
            end else begin
              r_data_out <= w_rd;
              r_id       <= r_id + 8'd1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign data_out  = r_data_out;
  assign leds      = r_leds;
  assign color     = r_color;
  assign cfg_wr    = r_cfg_wr;
  assign int_out_n = ~|(r_pending & r_mask);

endmodule
`default_nettype wire

// File: tb/tb_sysctrl_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sysctrl_gen
//  Purpose  : Directed bench for sysctrl_gen with a command-level model and
//             per-cycle output comparison.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sysctrl_gen;

  localparam int              TB_NVARS = 26;
  localparam int              TB_INT_W = 8;
  localparam logic [TB_NVARS*8-1:0] TB_CFG_INIT =
    {8'h5a, {23{8'h00}}, 8'hbb, 8'haa};

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    data_in_strobe;
  logic                    data_in_start;
  logic [7:0]              data_in;
  logic [7:0]              data_out;
  logic                    int_out_n;
  logic [TB_INT_W-2:0]     int_in;
  logic [1:0]              buttons;
  logic [1:0]              leds;
  logic [23:0]             color;
  logic [TB_NVARS*8-1:0]   cfg;
  logic [TB_NVARS-1:0]     cfg_wr;

  sysctrl_gen #(
    .CORE_ID  (8'h03),
    .NVARS    (TB_NVARS),
    .CFG_INIT (TB_CFG_INIT),
    .INT_W    (TB_INT_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .data_in_strobe (data_in_strobe),
    .data_in_start  (data_in_start),
    .data_in        (data_in),
    .data_out       (data_out),
    .int_out_n      (int_out_n),
    .int_in         (int_in),
    .buttons        (buttons),
    .leds           (leds),
    .color          (color),
    .cfg            (cfg),
    .cfg_wr         (cfg_wr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Command-level model of the endpoint's visible state.
  logic [7:0]          m_cmd, m_id, m_dout;
  int                  m_st;
  logic [1:0]          m_leds;
  logic [23:0]         m_color;
  logic [7:0]          m_cfg [TB_NVARS];
  logic [TB_NVARS-1:0] m_wr;
  logic [7:0]          m_pending, m_mask;
  logic [6:0]          m_prev;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic bit id_ok(input logic [7:0] id);
    return (id >= 8'h41) && (int'(id) - 8'h41 < TB_NVARS);
  endfunction

  task automatic model_reset();
    m_cmd = 0; m_id = 0; m_dout = 0; m_st = 0; m_leds = 0; m_color = 0;
    m_wr = 0; m_pending = 8'h01; m_mask = 8'h01; m_prev = 0;
    for (int k = 0; k < TB_NVARS; k++) m_cfg[k] = TB_CFG_INIT[k*8 +: 8];
  endtask

  task automatic model_apply(input logic stb, input logic start,
                             input logic [7:0] d, input logic [6:0] iin);
    logic [7:0] set_v, ack_v;
    set_v  = {iin & ~m_prev, 1'b0};
    m_prev = iin;
    ack_v  = 0;
    m_wr   = 0;
    if (stb && start) begin
      m_cmd = d;
      m_st  = 1;
    end else if (stb && m_st != 0) begin
      case (m_cmd)
        8'd0: if (m_st == 1) m_dout = 8'h5c; else if (m_st == 2) m_dout = 8'h42;
              else if (m_st == 3) m_dout = 8'h03; else if (m_st == 4) m_dout = 8'(TB_NVARS);
        8'd1: if (m_st == 1) m_leds = d[1:0];
        8'd2: if (m_st == 1) m_color[15:8] = rev8(d); else if (m_st == 2) m_color[7:0] = rev8(d);
              else if (m_st == 3) m_color[23:16] = rev8(d);
        8'd3: m_dout = {6'b0, buttons};
        8'd4: if (m_st == 1) m_id = d;
              else if (m_st == 2 && id_ok(m_id)) begin
                m_cfg[m_id - 8'h41] = d;
                m_wr[m_id - 8'h41]  = 1'b1;
              end
        8'd5: begin
          m_dout = m_pending;
          if (m_st == 1) ack_v = d;
        end
        8'd6: if (m_st == 1) m_mask = d | 8'h01;
`ifdef SYSCTRL_GEN_READBACK_EN
        8'd7: if (m_st == 1) m_id = d;
              else begin
                m_dout = id_ok(m_id) ? m_cfg[m_id - 8'h41] : 8'hff;
                m_id   = m_id + 8'd1;
              end
`endif
        default: ;
      endcase
      if (m_st < 15) m_st++;
    end
    m_pending = (m_pending & ~ack_v) | set_v;
  endtask

  function automatic logic [TB_NVARS*8-1:0] m_cfg_flat();
    logic [TB_NVARS*8-1:0] f;
    for (int k = 0; k < TB_NVARS; k++) f[k*8 +: 8] = m_cfg[k];
    return f;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("data_out",  256'(data_out),  256'(m_dout));
      chk("leds",      256'(leds),      256'(m_leds));
      chk("color",     256'(color),     256'(m_color));
      chk("cfg",       256'(cfg),       256'(m_cfg_flat()));
      chk("cfg_wr",    256'(cfg_wr),    256'(m_wr));
      chk("int_out_n", 256'(int_out_n), 256'(~|(m_pending & m_mask)));
    end
  end

  task automatic step(input logic stb, input logic start,
                      input logic [7:0] d, input logic [6:0] iin);
    data_in_strobe = stb;
    data_in_start  = start;
    data_in        = d;
    int_in         = iin;
    @(posedge clk);
    model_apply(stb, start, d, iin);
    #1;
  endtask

  task automatic send(input logic start, input logic [7:0] d);
    step(1'b1, start, d, 7'd0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 7'd0);
  endtask

  task automatic do_reset();
    data_in_strobe = 0; data_in_start = 0; data_in = 0; int_in = 0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b1;
  endtask

  initial begin
    buttons = 2'b00;
    do_reset();
    cmp_en = 1'b1;
    idle();
    chk("rst_data_out", 256'(data_out), 256'(8'h00));
    chk("rst_int_n",    256'(int_out_n), 256'(1'b0));
    chk("rst_cfg",      256'(cfg), 256'(TB_CFG_INIT));
    chk("rst_cfg_wr",   256'(cfg_wr), 256'(0));

    send(1, 8'h00);
    send(0, 8'h11); chk("st1_5c", 256'(data_out), 256'(8'h5c));
    send(0, 8'h11); chk("st2_42", 256'(data_out), 256'(8'h42));
    send(0, 8'h11); chk("st3_id", 256'(data_out), 256'(8'h03));
    send(0, 8'h11); chk("st4_nv", 256'(data_out), 256'(8'h1a));
    repeat (14) send(0, 8'h11);
    chk("st_sat", 256'(data_out), 256'(8'h1a));

    send(1, 8'h05); send(0, 8'h01);
    chk("ack_reply", 256'(data_out), 256'(8'h01));
    chk("ack_int_n", 256'(int_out_n), 256'(1'b1));
    send(1, 8'h05); send(0, 8'h00);
    chk("ack_reply2", 256'(data_out), 256'(8'h00));

    send(1, 8'h04); send(0, 8'h52); send(0, 8'h03);
    chk("cfg17", 256'(cfg[17*8 +: 8]), 256'(8'h03));
    chk("wr17",  256'(cfg_wr), 256'(26'd1 << 17));
    idle();
    chk("wr17_off", 256'(cfg_wr), 256'(0));
    send(1, 8'h04); send(0, 8'h5b); send(0, 8'h55);
    chk("oor_wr", 256'(cfg_wr), 256'(0));
    send(1, 8'h04); send(0, 8'h40); send(0, 8'h11);
    chk("low_wr", 256'(cfg_wr), 256'(0));
    send(1, 8'h04); send(0, 8'h5a); send(0, 8'h77);
    chk("cfg25", 256'(cfg[25*8 +: 8]), 256'(8'h77));
    chk("wr25",  256'(cfg_wr), 256'(26'd1 << 25));

    send(1, 8'h06); send(0, 8'h06);
    step(0, 0, 8'h00, 7'b0000010); idle();
    chk("ch2_int_n", 256'(int_out_n), 256'(1'b0));
    send(1, 8'h05); send(0, 8'h00);
    chk("pend04", 256'(data_out), 256'(8'h04));
    step(0, 0, 8'h00, 7'b0000100); idle();
    send(1, 8'h05); send(0, 8'h04);
    chk("pend0c", 256'(data_out), 256'(8'h0c));
    chk("bit3_masked", 256'(int_out_n), 256'(1'b1));
    send(1, 8'h05); step(1, 0, 8'h08, 7'b0000100); idle();
    send(1, 8'h05); send(0, 8'h00);
    chk("set_wins", 256'(data_out), 256'(8'h08));

    send(1, 8'h02); send(0, 8'h80); send(0, 8'h01); send(0, 8'hff);
    chk("color", 256'(color), 256'(24'hff0180));

    send(1, 8'h01); send(0, 8'h03);
    chk("leds3", 256'(leds), 256'(2'b11));
    buttons = 2'b10;
    send(1, 8'h03); send(0, 8'h00); send(0, 8'h00);
    chk("buttons", 256'(data_out), 256'(8'h02));

    send(1, 8'h09); send(0, 8'h12); send(0, 8'h34);
    chk("unk_dout", 256'(data_out), 256'(8'h02));
    chk("unk_leds", 256'(leds), 256'(2'b11));

`ifdef SYSCTRL_GEN_READBACK_EN
    send(1, 8'h07); send(0, 8'h41); send(0, 8'h00);
    chk("rb_A", 256'(data_out), 256'(8'haa));
    send(0, 8'h00);
    chk("rb_B", 256'(data_out), 256'(8'hbb));
    send(1, 8'h07); send(0, 8'h5a); send(0, 8'h00);
    chk("rb_Z", 256'(data_out), 256'(8'h77));
    send(0, 8'h00);
    chk("rb_oor", 256'(data_out), 256'(8'hff));
`else
    send(1, 8'h07); send(0, 8'h41); send(0, 8'h00);
    chk("cmd7_unk", 256'(data_out), 256'(8'h02));
`endif

    send(1, 8'h04); send(0, 8'h41);
    send(1, 8'h01); send(0, 8'h01);
    chk("restart_leds", 256'(leds), 256'(2'b01));
    chk("restart_cfg0", 256'(cfg[7:0]), 256'(8'haa));

    send(1, 8'h01);
    do_reset();
    send(0, 8'h02);
    chk("abort_leds",  256'(leds), 256'(2'b00));
    chk("abort_int_n", 256'(int_out_n), 256'(1'b0));
    repeat (3) idle();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
